// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
//
// Pipelined Y86 Execute-stage ALU with valid/ready handshakes on both sides
// and the architectural condition-code register (ZF/SF/OF).
//
// The arithmetic and flag generation are done combinationally in front of
// stage 1; stages 2..LATENCY only carry the precomputed result, flags and
// set_cc bit towards the output. Empty stages (bubbles) collapse, so a stall
// at the output only backs up as far as the first empty stage.
//
// Parameters:
//   WIDTH    operand/result width in bits (8..64)
//   LATENCY  number of pipeline stages (1..4)
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   flush             synchronous pipeline clear (CC register untouched)
//   in_valid/ready    input handshake; op/a/b/set_cc qualify in_valid
//   op                0=add (b+a), 1=sub (b-a), 2=and, 3=xor
//   out_valid/ready   output handshake; result/res_* qualify out_valid
//   cc_zf/sf/of       architectural condition codes
// ---------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             res_zf,
  output logic             res_sf,
  output logic             res_of,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam int         LAST   = LATENCY - 1;

  // Combinational ALU result and flags feeding stage 1
  logic [WIDTH-1:0] alu_res;
  logic             alu_zf;
  logic             alu_sf;
  logic             alu_of;
  logic             sign_a;
  logic             sign_b;
  logic             sign_r;

  // Per-stage storage; index 0 is stage 1, index LAST is the output stage
  logic [LATENCY-1:0]            valid_q, valid_d;
  logic [LATENCY-1:0][WIDTH-1:0] data_q, data_d;
  logic [LATENCY-1:0]            zf_q, zf_d;
  logic [LATENCY-1:0]            sf_q, sf_d;
  logic [LATENCY-1:0]            of_q, of_d;
  logic [LATENCY-1:0]            setcc_q, setcc_d;

  // take[i]: stage i loads from its predecessor at the next edge
  logic [LATENCY-1:0] take;

  // Architectural condition codes
  logic cc_zf_q, cc_zf_d;
  logic cc_sf_q, cc_sf_d;
  logic cc_of_q, cc_of_d;

  logic retire;

  // Y86 operand order: sub computes rB - rA, i.e. b - a. Overflow is judged
  // from the operand signs as the subtraction sees them (b minus a).
  always_comb begin
    sign_a  = a[WIDTH-1];
    sign_b  = b[WIDTH-1];
    alu_res = '0;
    alu_of  = 1'b0;
    case (op)
      OP_ADD:  alu_res = b + a;
      OP_SUB:  alu_res = b - a;
      OP_AND:  alu_res = b & a;
      default: alu_res = b ^ a;
    endcase
    sign_r = alu_res[WIDTH-1];
    case (op)
      OP_ADD:  alu_of = (sign_a == sign_b) && (sign_r != sign_a);
      OP_SUB:  alu_of = (sign_a != sign_b) && (sign_r != sign_b);
      default: alu_of = 1'b0;
    endcase
    alu_zf = (alu_res == '0);
    alu_sf = sign_r;
  end

  // Ready chain from the output backwards: a stage can load if it is empty
  // or if whatever it holds is leaving at the same edge.
  always_comb begin
    logic chain;
    take       = '0;
    chain      = !valid_q[LAST] || out_ready;
    take[LAST] = chain;
    for (int i = LATENCY - 2; i >= 0; i--) begin
      chain   = !valid_q[i] || chain;
      take[i] = chain;
    end
  end

  // Stage shifting. A stage that takes copies its predecessor wholesale,
  // including an empty predecessor, which is how bubbles disappear. Flush
  // empties every stage and thereby drops any input transfer this cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    of_d    = of_q;
    setcc_d = setcc_q;
    if (take[0]) begin
      valid_d[0] = in_valid;
      data_d[0]  = alu_res;
      zf_d[0]    = alu_zf;
      sf_d[0]    = alu_sf;
      of_d[0]    = alu_of;
      setcc_d[0] = set_cc;
    end
    for (int i = 1; i < LATENCY; i++) begin
      if (take[i]) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
        zf_d[i]    = zf_q[i-1];
        sf_d[i]    = sf_q[i-1];
        of_d[i]    = of_q[i-1];
        setcc_d[i] = setcc_q[i-1];
      end
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  // A retirement during a flush is not architecturally committed, so it
  // leaves the condition codes alone.
  always_comb begin
    retire  = valid_q[LAST] && out_ready;
    cc_zf_d = cc_zf_q;
    cc_sf_d = cc_sf_q;
    cc_of_d = cc_of_q;
    if (retire && setcc_q[LAST] && !flush) begin
      cc_zf_d = zf_q[LAST];
      cc_sf_d = sf_q[LAST];
      cc_of_d = of_q[LAST];
    end
  end

  // Reset clears data as well as valids so the outputs read as zero, and
  // puts the CC register in its "result was zero" state.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      zf_q    <= '0;
      sf_q    <= '0;
      of_q    <= '0;
      setcc_q <= '0;
      cc_zf_q <= 1'b1;
      cc_sf_q <= 1'b0;
      cc_of_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
      setcc_q <= setcc_d;
      cc_zf_q <= cc_zf_d;
      cc_sf_q <= cc_sf_d;
      cc_of_q <= cc_of_d;
    end
  end

  assign in_ready  = take[0];
  assign out_valid = valid_q[LAST];
  assign result    = data_q[LAST];
  assign res_zf    = zf_q[LAST];
  assign res_sf    = sf_q[LAST];
  assign res_of    = of_q[LAST];
  assign cc_zf     = cc_zf_q;
  assign cc_sf     = cc_sf_q;
  assign cc_of     = cc_of_q;

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe
//
// Drives two alu_pipe instances: a 64-bit, two-stage one (suffix _w) and an
// 8-bit, four-stage one (suffix _s). Expected results come from ref_op, which
// evaluates each operation with wide signed integer arithmetic, and from a
// queue of in-flight operations tagged with their acceptance cycle.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int WW = 64;
  localparam int LW = 2;
  localparam int WS = 8;
  localparam int LS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic        rst_w, flush_w, in_valid_w, in_ready_w, set_cc_w;
  logic        out_valid_w, out_ready_w;
  logic [1:0]  op_w;
  logic [63:0] a_w, b_w, result_w;
  logic        res_zf_w, res_sf_w, res_of_w, cc_zf_w, cc_sf_w, cc_of_w;

  logic        rst_s, flush_s, in_valid_s, in_ready_s, set_cc_s;
  logic        out_valid_s, out_ready_s;
  logic [1:0]  op_s;
  logic [7:0]  a_s, b_s, result_s;
  logic        res_zf_s, res_sf_s, res_of_s, cc_zf_s, cc_sf_s, cc_of_s;

  int errors = 0;
  int checks = 0;

  logic [2:0] cc_mw;
  logic [2:0] cc_ms;

  typedef struct packed {
    logic [63:0] res;
    logic        zf;
    logic        sf;
    logic        of;
    logic        sc;
    int          t;
  } exp_t;

  alu_pipe #(.WIDTH(WW), .LATENCY(LW)) u_dut_w (
    .clk(clk), .rst(rst_w), .flush(flush_w),
    .in_valid(in_valid_w), .in_ready(in_ready_w),
    .op(op_w), .a(a_w), .b(b_w), .set_cc(set_cc_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w),
    .result(result_w), .res_zf(res_zf_w), .res_sf(res_sf_w), .res_of(res_of_w),
    .cc_zf(cc_zf_w), .cc_sf(cc_sf_w), .cc_of(cc_of_w)
  );

  alu_pipe #(.WIDTH(WS), .LATENCY(LS)) u_dut_s (
    .clk(clk), .rst(rst_s), .flush(flush_s),
    .in_valid(in_valid_s), .in_ready(in_ready_s),
    .op(op_s), .a(a_s), .b(b_s), .set_cc(set_cc_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s),
    .result(result_s), .res_zf(res_zf_s), .res_sf(res_sf_s), .res_of(res_of_s),
    .cc_zf(cc_zf_s), .cc_sf(cc_sf_s), .cc_of(cc_of_s)
  );

  // Reference: interpret operands as w-bit two's-complement integers, do the
  // arithmetic exactly, then wrap to w bits; overflow means the exact value
  // does not fit the signed w-bit range.
  function automatic exp_t ref_op(input int w, input logic [1:0] op,
                                  input logic [63:0] a_in, input logic [63:0] b_in,
                                  input logic sc);
    exp_t e;
    logic signed [127:0] sa, sb, t, lim;
    logic [63:0] mask, a, b;
    e    = '0;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    a    = a_in & mask;
    b    = b_in & mask;
    sa   = $signed({64'd0, a});
    sb   = $signed({64'd0, b});
    if (a[w-1]) sa = sa - (128'sd1 <<< w);
    if (b[w-1]) sb = sb - (128'sd1 <<< w);
    lim  = 128'sd1 <<< (w - 1);
    case (op)
      2'd0: begin t = sb + sa; e.of = (t >= lim) || (t < -lim); end
      2'd1: begin t = sb - sa; e.of = (t >= lim) || (t < -lim); end
      2'd2: t = $signed({64'd0, a & b});
      default: t = $signed({64'd0, a ^ b});
    endcase
    e.res = t[63:0] & mask;
    e.zf  = (e.res == 64'd0);
    e.sf  = e.res[w-1];
    e.sc  = sc;
    return e;
  endfunction

  task automatic idle_w();
    in_valid_w = 1'b0; flush_w = 1'b0; op_w = 2'd0; a_w = '0; b_w = '0; set_cc_w = 1'b0;
  endtask

  task automatic idle_s();
    in_valid_s = 1'b0; flush_s = 1'b0; op_s = 2'd0; a_s = '0; b_s = '0; set_cc_s = 1'b0;
  endtask

  // Presents one op to the wide DUT on an empty pipeline and returns how many
  // edges (counting the acceptance edge) until out_valid is seen; -1 if never.
  task automatic issue_w(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic sc, output int lat);
    op_w = op; a_w = a; b_w = b; set_cc_w = sc; in_valid_w = 1'b1; out_ready_w = 1'b1;
    #1;
    for (int k = 0; k < 20 && !in_ready_w; k++) begin
      @(negedge clk); #1;
    end
    @(negedge clk);
    in_valid_w = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      #1;
      if (out_valid_w) begin lat = k; break; end
      @(negedge clk);
    end
  endtask

  task automatic issue_s(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic sc, output int lat);
    op_s = op; a_s = a; b_s = b; set_cc_s = sc; in_valid_s = 1'b1; out_ready_s = 1'b1;
    #1;
    for (int k = 0; k < 20 && !in_ready_s; k++) begin
      @(negedge clk); #1;
    end
    @(negedge clk);
    in_valid_s = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      #1;
      if (out_valid_s) begin lat = k; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    idle_w(); idle_s();
    rst_w = 1'b1; rst_s = 1'b1; out_ready_w = 1'b1; out_ready_s = 1'b1;
    repeat (2) @(negedge clk);
    rst_w = 1'b0; rst_s = 1'b0;
    #1;
    checks++; if (out_valid_w !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid_w: got %b expected 0", out_valid_w); end
    checks++; if (result_w !== 64'd0) begin errors++; $display("[TB] FAIL reset_result_w: got %h expected 0", result_w); end
    checks++; if ({res_zf_w, res_sf_w, res_of_w} !== 3'b000) begin errors++; $display("[TB] FAIL reset_res_flags_w: got %b expected 000", {res_zf_w, res_sf_w, res_of_w}); end
    checks++; if ({cc_zf_w, cc_sf_w, cc_of_w} !== 3'b100) begin errors++; $display("[TB] FAIL reset_cc_w: got %b expected 100", {cc_zf_w, cc_sf_w, cc_of_w}); end
    checks++; if (in_ready_w !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready_w: got %b expected 1", in_ready_w); end
    checks++; if (out_valid_s !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid_s: got %b expected 0", out_valid_s); end
    checks++; if (result_s !== 8'd0) begin errors++; $display("[TB] FAIL reset_result_s: got %h expected 0", result_s); end
    checks++; if ({cc_zf_s, cc_sf_s, cc_of_s} !== 3'b100) begin errors++; $display("[TB] FAIL reset_cc_s: got %b expected 100", {cc_zf_s, cc_sf_s, cc_of_s}); end
    checks++; if (in_ready_s !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready_s: got %b expected 1", in_ready_s); end
    cc_mw = 3'b100;
    cc_ms = 3'b100;
  endtask

  task automatic test_ops_w();
    logic [1:0]  opv [5];
    logic [63:0] av  [5];
    logic [63:0] bv  [5];
    logic        scv [5];
    exp_t e;
    int lat;
    opv = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd2};
    av  = '{64'hD3, 64'h1, 64'hFFFF, 64'h4000_0000_0000_0000, 64'hF0F0};
    bv  = '{64'hD3, 64'h8000_0000_0000_0000, 64'h1234, 64'h4000_0000_0000_0000, 64'h0FF0};
    scv = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      e = ref_op(WW, opv[i], av[i], bv[i], scv[i]);
      issue_w(opv[i], av[i], bv[i], scv[i], lat);
      checks++; if (lat != LW) begin errors++; $display("[TB] FAIL ops_latency[%0d]: got %0d expected %0d", i, lat, LW); end
      checks++; if (result_w !== e.res) begin errors++; $display("[TB] FAIL ops_result[%0d]: got %h expected %h", i, result_w, e.res); end
      checks++; if ({res_zf_w, res_sf_w, res_of_w} !== {e.zf, e.sf, e.of}) begin errors++; $display("[TB] FAIL ops_flags[%0d]: got %b expected %b", i, {res_zf_w, res_sf_w, res_of_w}, {e.zf, e.sf, e.of}); end
      if (scv[i]) cc_mw = {e.zf, e.sf, e.of};
      @(negedge clk); #1;
      checks++; if ({cc_zf_w, cc_sf_w, cc_of_w} !== cc_mw) begin errors++; $display("[TB] FAIL ops_cc[%0d]: got %b expected %b", i, {cc_zf_w, cc_sf_w, cc_of_w}, cc_mw); end
      checks++; if (out_valid_w !== 1'b0) begin errors++; $display("[TB] FAIL ops_single_retire[%0d]: got out_valid %b expected 0", i, out_valid_w); end
    end
  endtask

  task automatic test_back_to_back_w();
    exp_t q[$];
    exp_t e;
    int sent = 0;
    int got = 0;
    logic stalled = 1'b0;
    logic [67:0] snap = '0;
    logic [1:0]  opv [6];
    logic [63:0] av  [6];
    logic [63:0] bv  [6];
    logic        scv [6];
    for (int i = 0; i < 6; i++) begin
      opv[i] = 2'($urandom_range(0, 3));
      av[i]  = {$urandom, $urandom};
      bv[i]  = {$urandom, $urandom};
      scv[i] = 1'($urandom_range(0, 1));
    end
    for (int c = 0; c < 40 && got < 6; c++) begin
      out_ready_w = (c >= 4);
      if (sent < 6) begin
        op_w = opv[sent]; a_w = av[sent]; b_w = bv[sent]; set_cc_w = scv[sent]; in_valid_w = 1'b1;
      end else begin
        in_valid_w = 1'b0;
      end
      #1;
      if (c < 4) begin
        checks++; if (in_ready_w !== (sent < LW)) begin errors++; $display("[TB] FAIL b2b_in_ready[c%0d]: got %b expected %b", c, in_ready_w, (sent < LW)); end
      end
      if (stalled) begin
        checks++; if ({out_valid_w, result_w, res_zf_w, res_sf_w, res_of_w} !== snap) begin errors++; $display("[TB] FAIL b2b_stall_stable[c%0d]: got %h expected %h", c, {out_valid_w, result_w, res_zf_w, res_sf_w, res_of_w}, snap); end
      end
      if (out_valid_w && out_ready_w) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("[TB] FAIL b2b_extra_output[c%0d]: got result %h expected none", c, result_w);
        end else begin
          e = q.pop_front();
          if ({result_w, res_zf_w, res_sf_w, res_of_w} !== {e.res, e.zf, e.sf, e.of}) begin
            errors++; $display("[TB] FAIL b2b_order[%0d]: got %h/%b expected %h/%b", got, result_w, {res_zf_w, res_sf_w, res_of_w}, e.res, {e.zf, e.sf, e.of});
          end
          if (e.sc) cc_mw = {e.zf, e.sf, e.of};
        end
        got++;
      end
      if (in_valid_w && in_ready_w) begin
        q.push_back(ref_op(WW, op_w, a_w, b_w, set_cc_w));
        sent++;
      end
      stalled = out_valid_w && !out_ready_w;
      snap    = {out_valid_w, result_w, res_zf_w, res_sf_w, res_of_w};
      @(negedge clk);
    end
    in_valid_w = 1'b0;
    checks++; if (got != 6) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 6", got); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (out_valid_w !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_dup: got out_valid %b expected 0", out_valid_w); end
    checks++; if ({cc_zf_w, cc_sf_w, cc_of_w} !== cc_mw) begin errors++; $display("[TB] FAIL b2b_cc: got %b expected %b", {cc_zf_w, cc_sf_w, cc_of_w}, cc_mw); end
  endtask

  task automatic test_flush_w();
    exp_t e;
    int lat;
    logic [2:0] cc_before;
    e = ref_op(WW, 2'd3, 64'h55, 64'h55, 1'b1);
    issue_w(2'd3, 64'h55, 64'h55, 1'b1, lat);
    cc_mw = {e.zf, e.sf, e.of};
    @(negedge clk);
    cc_before = cc_mw;
    out_ready_w = 1'b1; op_w = 2'd1; a_w = 64'd1; b_w = 64'd0; set_cc_w = 1'b1; in_valid_w = 1'b1;
    @(negedge clk);
    a_w = 64'd2;
    @(negedge clk);
    flush_w = 1'b1; a_w = 64'd3;
    #1;
    checks++; if (out_valid_w !== 1'b1) begin errors++; $display("[TB] FAIL flush_setup: got out_valid %b expected 1", out_valid_w); end
    @(negedge clk);
    flush_w = 1'b0; in_valid_w = 1'b0;
    #1;
    checks++; if (out_valid_w !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid: got %b expected 0", out_valid_w); end
    checks++; if ({cc_zf_w, cc_sf_w, cc_of_w} !== cc_before) begin errors++; $display("[TB] FAIL flush_cc: got %b expected %b", {cc_zf_w, cc_sf_w, cc_of_w}, cc_before); end
    checks++; if (in_ready_w !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready: got %b expected 1", in_ready_w); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++; if (out_valid_w !== 1'b0) begin errors++; $display("[TB] FAIL flush_dropped[%0d]: got out_valid %b expected 0", k, out_valid_w); end
    end
    checks++; if ({cc_zf_w, cc_sf_w, cc_of_w} !== cc_before) begin errors++; $display("[TB] FAIL flush_cc_after: got %b expected %b", {cc_zf_w, cc_sf_w, cc_of_w}, cc_before); end
  endtask

  task automatic test_random_w();
    exp_t q[$];
    exp_t e;
    logic stalled = 1'b0;
    logic [67:0] snap = '0;
    logic exp_ov;
    logic exp_rdy;
    for (int c = 0; c < 400; c++) begin
      in_valid_w  = ($urandom_range(0, 9) < 7);
      out_ready_w = ($urandom_range(0, 9) < 6);
      flush_w     = ($urandom_range(0, 49) == 0);
      op_w        = 2'($urandom_range(0, 3));
      a_w         = {$urandom, $urandom};
      b_w         = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) b_w = a_w;
      set_cc_w    = 1'($urandom_range(0, 1));
      #1;
      checks++; if ({cc_zf_w, cc_sf_w, cc_of_w} !== cc_mw) begin errors++; $display("[TB] FAIL rand_cc[c%0d]: got %b expected %b", c, {cc_zf_w, cc_sf_w, cc_of_w}, cc_mw); end
      exp_rdy = (q.size() < LW) || out_ready_w;
      checks++; if (in_ready_w !== exp_rdy) begin errors++; $display("[TB] FAIL rand_in_ready[c%0d]: got %b expected %b", c, in_ready_w, exp_rdy); end
      exp_ov = (q.size() != 0) && ((edge_cnt - q[0].t) >= LW);
      checks++; if (out_valid_w !== exp_ov) begin errors++; $display("[TB] FAIL rand_out_valid[c%0d]: got %b expected %b", c, out_valid_w, exp_ov); end
      if (stalled) begin
        checks++; if ({out_valid_w, result_w, res_zf_w, res_sf_w, res_of_w} !== snap) begin errors++; $display("[TB] FAIL rand_stall_stable[c%0d]: got %h expected %h", c, {out_valid_w, result_w, res_zf_w, res_sf_w, res_of_w}, snap); end
      end
      if (out_valid_w && q.size() != 0) begin
        checks++; if ({result_w, res_zf_w, res_sf_w, res_of_w} !== {q[0].res, q[0].zf, q[0].sf, q[0].of}) begin errors++; $display("[TB] FAIL rand_data[c%0d]: got %h/%b expected %h/%b", c, result_w, {res_zf_w, res_sf_w, res_of_w}, q[0].res, {q[0].zf, q[0].sf, q[0].of}); end
      end
      if (out_valid_w && out_ready_w && q.size() != 0) begin
        e = q.pop_front();
        if (e.sc && !flush_w) cc_mw = {e.zf, e.sf, e.of};
      end
      if (flush_w) begin
        q.delete();
      end else if (in_valid_w && in_ready_w) begin
        e   = ref_op(WW, op_w, a_w, b_w, set_cc_w);
        e.t = edge_cnt;
        q.push_back(e);
      end
      stalled = out_valid_w && !out_ready_w && !flush_w;
      snap    = {out_valid_w, result_w, res_zf_w, res_sf_w, res_of_w};
      @(negedge clk);
    end
    in_valid_w = 1'b0; flush_w = 1'b1;
    @(negedge clk);
    flush_w = 1'b0;
    #1;
    checks++; if ({cc_zf_w, cc_sf_w, cc_of_w} !== cc_mw) begin errors++; $display("[TB] FAIL rand_cc_final: got %b expected %b", {cc_zf_w, cc_sf_w, cc_of_w}, cc_mw); end
  endtask

  task automatic test_reset_mid_s();
    exp_t e;
    int lat;
    out_ready_s = 1'b1; op_s = 2'd0; a_s = 8'h01; b_s = 8'h7F; set_cc_s = 1'b1; in_valid_s = 1'b1;
    repeat (6) @(negedge clk);
    e = ref_op(WS, 2'd0, 64'h01, 64'h7F, 1'b1);
    cc_ms = {e.zf, e.sf, e.of};
    #1;
    checks++; if (out_valid_s !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_inflight: got out_valid %b expected 1", out_valid_s); end
    checks++; if ({cc_zf_s, cc_sf_s, cc_of_s} !== cc_ms) begin errors++; $display("[TB] FAIL rstmid_cc_before: got %b expected %b", {cc_zf_s, cc_sf_s, cc_of_s}, cc_ms); end
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0; in_valid_s = 1'b0;
    cc_ms = 3'b100;
    #1;
    checks++; if (out_valid_s !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_out_valid: got %b expected 0", out_valid_s); end
    checks++; if (result_s !== 8'd0) begin errors++; $display("[TB] FAIL rstmid_result: got %h expected 0", result_s); end
    checks++; if ({res_zf_s, res_sf_s, res_of_s} !== 3'b000) begin errors++; $display("[TB] FAIL rstmid_res_flags: got %b expected 000", {res_zf_s, res_sf_s, res_of_s}); end
    checks++; if ({cc_zf_s, cc_sf_s, cc_of_s} !== cc_ms) begin errors++; $display("[TB] FAIL rstmid_cc: got %b expected %b", {cc_zf_s, cc_sf_s, cc_of_s}, cc_ms); end
    checks++; if (in_ready_s !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_in_ready: got %b expected 1", in_ready_s); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      checks++; if (out_valid_s !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_discard[%0d]: got out_valid %b expected 0", k, out_valid_s); end
    end
    e = ref_op(WS, 2'd0, 64'h7F, 64'h01, 1'b1);
    issue_s(2'd0, 8'h7F, 8'h01, 1'b1, lat);
    checks++; if (lat != LS) begin errors++; $display("[TB] FAIL rstmid_new_latency: got %0d expected %0d", lat, LS); end
    checks++; if (result_s !== e.res[7:0]) begin errors++; $display("[TB] FAIL rstmid_new_result: got %h expected %h", result_s, e.res[7:0]); end
    checks++; if ({res_zf_s, res_sf_s, res_of_s} !== {e.zf, e.sf, e.of}) begin errors++; $display("[TB] FAIL rstmid_new_flags: got %b expected %b", {res_zf_s, res_sf_s, res_of_s}, {e.zf, e.sf, e.of}); end
    cc_ms = {e.zf, e.sf, e.of};
    @(negedge clk); #1;
    checks++; if ({cc_zf_s, cc_sf_s, cc_of_s} !== cc_ms) begin errors++; $display("[TB] FAIL rstmid_new_cc: got %b expected %b", {cc_zf_s, cc_sf_s, cc_of_s}, cc_ms); end
  endtask

  initial begin
    idle_w(); idle_s();
    rst_w = 1'b1; rst_s = 1'b1; out_ready_w = 1'b1; out_ready_s = 1'b1;
    cc_mw = 3'b100; cc_ms = 3'b100;
    test_reset();
    test_ops_w();
    test_back_to_back_w();
    test_flush_w();
    test_random_w();
    test_reset_mid_s();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
